// File: rtl/ex_trace_buffer.sv
// ex_trace_buffer: circular EX-stage trace recorder that freezes a fixed number of entries after an exception and drains through a show-ahead read port
module ex_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int POST_TRIG = 4
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              EX_valid,
  input  logic [31:0]       EX_instruction,
  input  logic [2:0]        EX_exception_signal,
  input  logic [7:0]        EX_status_out,
  input  logic              arm,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_instruction,
  output logic [2:0]        rd_exception,
  output logic [7:0]        rd_status,
  output logic [PTR_W:0]    count,
  output logic [1:0]        state,
  output logic              overflow,
  output logic [31:0]       trig_instruction
);
  typedef enum logic [1:0] {ARMED = 2'd0, POST = 2'd1, FROZEN = 2'd2} state_t;
  state_t             r_state;
  logic [42:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   r_post;
  logic               r_overflow;
  logic [31:0]        r_trig;
  logic               w_cap;
  logic               w_pop;
  logic               w_full;
  logic               w_exc;
  logic [42:0]        w_head_entry;
  assign w_cap        = EX_valid && (r_state != FROZEN);
  assign w_pop        = (r_count != '0) && rd_ready;
  assign w_full       = r_count == (PTR_W+1)'(DEPTH);
  assign w_exc        = EX_exception_signal != 3'd0;
  assign w_head_entry = r_mem[r_head];
  assign rd_valid         = r_count != '0;
  assign rd_instruction   = w_head_entry[42:11];
  assign rd_exception     = w_head_entry[10:8];
  assign rd_status        = w_head_entry[7:0];
  assign count            = r_count;
  assign state            = r_state;
  assign overflow         = r_overflow;
  assign trig_instruction = r_trig;
  // Trace storage; arm discards a same-cycle capture, so it also blocks the write
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset && !arm && w_cap) r_mem[r_tail] <= {EX_instruction, EX_exception_signal, EX_status_out};
  end
  // Pointers, occupancy, overflow flag and the ARMED/POST/FROZEN sequencer
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      r_state    <= ARMED;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_overflow <= 1'b0;
      r_trig     <= '0;
    end else if (arm) begin
      r_state    <= ARMED;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_cap) r_tail <= r_tail + PTR_W'(1);
      if (w_pop || (w_cap && w_full)) r_head <= r_head + PTR_W'(1);
      if (w_cap && !w_pop && !w_full) r_count <= r_count + (PTR_W+1)'(1);
      if (!w_cap && w_pop) r_count <= r_count - (PTR_W+1)'(1);
      if (w_cap && !w_pop && w_full) r_overflow <= 1'b1;
      if (w_cap && r_state == ARMED && w_exc) begin
        r_trig  <= EX_instruction;
        r_post  <= PTR_W'(POST_TRIG);
        r_state <= (POST_TRIG == 0) ? FROZEN : POST;
      end
      if (w_cap && r_state == POST) begin
        r_post  <= r_post - PTR_W'(1);
        r_state <= (r_post == PTR_W'(1)) ? FROZEN : POST;
      end
    end
  end
endmodule

// File: tb/tb_ex_trace_buffer.sv
// tb_ex_trace_buffer: directed checks of capture, wrap/overflow, trigger/freeze, arm and reset
module tb_ex_trace_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_instr = '0;
  logic [2:0]  ex_exc = '0;
  logic [7:0]  ex_status = '0;
  logic        arm = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_instruction;
  logic [2:0]  rd_exception;
  logic [7:0]  rd_status;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;
  logic [31:0] trig_instruction;
  int errors = 0;
  int checks = 0;
  ex_trace_buffer #(.DEPTH(16), .PTR_W(4), .POST_TRIG(4)) dut (
    .SYS_clk(clk), .SYS_reset(rst_n), .EX_valid(ex_valid), .EX_instruction(ex_instr),
    .EX_exception_signal(ex_exc), .EX_status_out(ex_status), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_instruction(rd_instruction), .rd_exception(rd_exception),
    .rd_status(rd_status), .count(count), .state(state), .overflow(overflow),
    .trig_instruction(trig_instruction)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cap(input logic [31:0] instr, input logic [2:0] exc, input logic [7:0] st);
    ex_instr = instr; ex_exc = exc; ex_status = st; ex_valid = 1'b1;
    step();
    ex_valid = 1'b0; ex_exc = '0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask
  initial begin
    step(); step();
    rst_n = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_trig", trig_instruction, 0);
    for (int i = 1; i <= 3; i++) cap(32'h20080000 + 32'(i), 3'd0, 8'h10);
    chk("t1_count", 32'(count), 3);
    chk("t1_state", 32'(state), 0);
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_head", rd_instruction, 32'h20080001);
    chk("t1_status", 32'(rd_status), 32'h10);
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("t1_pop", rd_instruction, 32'h20080000 + 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t1_empty_count", 32'(count), 0);
    chk("t1_empty_valid", 32'(rd_valid), 0);
    for (int i = 0; i < 20; i++) cap(32'(i), 3'd0, 8'h00);
    chk("t2_count", 32'(count), 16);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_head", rd_instruction, 32'h4);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", rd_instruction, 32'h4 + 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("t2_drained", 32'(count), 0);
    chk("t2_ovf_sticky", 32'(overflow), 1);
    do_arm();
    chk("t2_arm_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) cap(32'h100 + 32'(i), 3'd0, 8'h00);
    chk("t3_full", 32'(count), 16);
    ex_instr = 32'h200; ex_valid = 1'b1; rd_ready = 1'b1;
    #1;
    chk("t3_popped", rd_instruction, 32'h100);
    step();
    ex_valid = 1'b0; rd_ready = 1'b0;
    chk("t3_count", 32'(count), 16);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_head", rd_instruction, 32'h101);
    do_arm();
    cap(32'h300, 3'd0, 8'h01);
    cap(32'h301, 3'd0, 8'h02);
    chk("t4_armed", 32'(state), 0);
    cap(32'h8C000000, 3'd3, 8'h03);
    chk("t4_post", 32'(state), 1);
    chk("t4_trig", trig_instruction, 32'h8C000000);
    for (int i = 0; i < 6; i++) begin
      cap(32'h400 + 32'(i), (i == 1) ? 3'd5 : 3'd0, 8'h00);
      if (i == 2) chk("t4_still_post", 32'(state), 1);
      if (i == 3) chk("t4_frozen", 32'(state), 2);
    end
    chk("t4_count", 32'(count), 7);
    chk("t4_state_end", 32'(state), 2);
    chk("t4_trig_kept", trig_instruction, 32'h8C000000);
    chk("t4_head", rd_instruction, 32'h300);
    chk("t4_head_status", 32'(rd_status), 1);
    arm = 1'b1; ex_valid = 1'b1; rd_ready = 1'b1; ex_instr = 32'h500;
    step();
    arm = 1'b0; ex_valid = 1'b0; rd_ready = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_state", 32'(state), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_valid", 32'(rd_valid), 0);
    chk("t5_trig", trig_instruction, 32'h8C000000);
    cap(32'h8C000010, 3'd1, 8'h00);
    chk("t6_trig", trig_instruction, 32'h8C000010);
    cap(32'h600, 3'd0, 8'h00);
    cap(32'h601, 3'd0, 8'h00);
    chk("t6_post", 32'(state), 1);
    chk("t6_count", 32'(count), 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_state", 32'(state), 0);
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_trig_rst", trig_instruction, 0);
    chk("t6_valid", 32'(rd_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
